avg_acq_ctrl: RTL
=================

Name: avg_acq_ctrl

Overview:
Acquisition sequencer for the decimating moving-average filter. It latches the decimation exponent k and the number of output samples per acquisition, and resets the averager cleanly at the start of every acquisition so k never changes mid-block. It then gates ADC sample strobes into the averager, counts the decimated outputs, and reports done or aborted. It sits between the ADC front end / configuration registers and the averager instance.

Parameters:
BITS_ADC, 8, ADC sample width. Forwarded unchanged to the averager.
BITS_ACUM, 12, averager accumulator width. BIT_DIFF = BITS_ACUM-BITS_ADC.
BITS_NSAMP, 16, width of the output-sample count and its configuration.

Ports:
clk  in  1  fpga clock
rst  in  1  reset; synchronous, active-high
start  in  1  single-cycle acquisition request; honoured only in IDLE
abort  in  1  single-cycle stop request; honoured in LOAD or RUN
k_cfg  in  $clog2(BIT_DIFF)  requested k = log2(decimation factor)
n_samples_cfg  in  BITS_NSAMP  output samples per acquisition; 0 = continuous
adc_rdy  in  1  raw ADC sample strobe
avg_rdy_out  in  1  output strobe from the averager
avg_rst  out  1  averager reset
avg_k  out  $clog2(BIT_DIFF)  latched k driven to the averager
avg_rdy_in  out  1  gated sample strobe to the averager
busy  out  1  acquisition in progress
done  out  1  one-cycle pulse on normal completion
aborted  out  1  one-cycle pulse on abort
out_cnt  out  BITS_NSAMP  averager outputs counted in the current acquisition

Behaviour:
- States: IDLE, LOAD, RUN, DONE. Encoding is free.
- Reset (rst=1 at a clock edge), from any state, including mid-RUN:
  - state=IDLE; avg_k=0; out_cnt=0; internal n register=0; aborted=0.
  - avg_rst = rst OR (state==LOAD), combinational, so the averager is held in reset while rst is high.
- Decoded outputs: busy = LOAD|RUN; done = (state==DONE); avg_rdy_in = adc_rdy AND state==RUN.
- IDLE:
  - start=1 and abort=0: latch avg_k <= min(k_cfg, BIT_DIFF-1), latch n_r <= n_samples_cfg, clear out_cnt, go to LOAD.
  - start=1 and abort=1 in the same cycle: stay IDLE, no pulses.
  - Otherwise hold. avg_k and out_cnt keep their last values after an acquisition so software can read them.
- LOAD (exactly 1 cycle):
  - avg_rst=1, which loads the averager's down-counter from 1<<avg_k and clears its accumulator.
  - Next state RUN. abort=1 here: go IDLE, aborted pulses the next cycle.
- RUN:
  - adc_rdy is passed combinationally to avg_rdy_in. The first strobe forwarded is the one in the first RUN cycle, i.e. 2 cycles after the cycle in which start is sampled.
  - On avg_rdy_out=1: out_cnt <= out_cnt+1.
  - If n_r!=0 and out_cnt==n_r-1, go to DONE instead of staying in RUN. Gating closes from the DONE cycle on; a straggler strobe is discarded and the next LOAD re-resets the averager.
  - n_r==0 (continuous mode): never self-terminates. out_cnt wraps 2^BITS_NSAMP-1 -> 0.
  - abort=1: go IDLE, aborted=1 for one cycle (registered). abort wins over a simultaneous final avg_rdy_out: no done pulse and out_cnt is not incremented.
  - start is ignored.
- DONE: done=1 for exactly 1 cycle, then IDLE. start and abort are ignored in this cycle.
- avg_rdy_out outside RUN is ignored; out_cnt is unchanged.
- k clamp: the averager's down-counter is BIT_DIFF bits wide, so 1<<BIT_DIFF would wrap to 0. Values above BIT_DIFF-1 are clamped to BIT_DIFF-1.
- n_samples_cfg and k_cfg changing during LOAD/RUN have no effect until the next start.
- No combinational path from any input to busy, done or aborted.

Test Plan:
- Reset during RUN (out_cnt=5) -> next cycle: IDLE, busy=0, out_cnt=0, avg_k=0, avg_rst=1 while rst=1; no done or aborted pulse.
- start with k_cfg=2, n_samples_cfg=3, adc_rdy every cycle, behavioural averager -> avg_rst high exactly 1 cycle, avg_k=2, 12 strobes forwarded, out_cnt 1,2,3, done pulses once the cycle after the 3rd avg_rdy_out, busy falls with it.
- n_samples_cfg=0, k_cfg=0, BITS_NSAMP=4, 20 strobes -> out_cnt wraps 15->0 and reads 4, no done; then abort -> aborted pulse, state IDLE, avg_rdy_in=0 thereafter.
- abort coincident with the 3rd (final) avg_rdy_out, n=3 -> aborted=1, done never asserted, out_cnt=2.
- start+abort same cycle in IDLE -> no LOAD, avg_rst stays 0; start during RUN -> ignored, out_cnt unaffected; k_cfg change mid-RUN -> avg_k unchanged until the next start.
- Clamp check, BITS_ACUM=11, BITS_ADC=8 (BIT_DIFF=3, 2-bit k) -> k_cfg=3 latches avg_k=2; adc_rdy while IDLE -> avg_rdy_in stays 0.

Source files
------------

// File: rtl/avg_acq_ctrl.sv
// avg_acq_ctrl
// Acquisition sequencer for the decimating moving-average filter. It latches
// the decimation exponent k and the output-sample count when an acquisition
// starts. It resets the averager for one cycle so that k never changes inside
// a block. It then gates ADC strobes into the averager, counts the decimated
// outputs, and reports normal completion or abort.
//
// Ports
//   clk            clock
//   rst            synchronous, active-high reset
//   start          one-cycle acquisition request, honoured only while idle
//   abort          one-cycle stop request, honoured in LOAD or RUN
//   k_cfg          requested k = log2(decimation factor)
//   n_samples_cfg  outputs per acquisition; 0 runs continuously
//   adc_rdy        raw ADC sample strobe
//   avg_rdy_out    output strobe from the averager
//   avg_rst        averager reset (held while rst is high, and during LOAD)
//   avg_k          latched, clamped k driven to the averager
//   avg_rdy_in     ADC strobe gated to the RUN state
//   busy           acquisition in progress (LOAD or RUN)
//   done           one-cycle pulse on normal completion
//   aborted        one-cycle pulse after an abort
//   out_cnt        averager outputs counted in the current acquisition
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; avg_k/out_cnt keep last acquisition values
// LOAD  | one cycle of averager reset with the new k
// RUN   | strobes forwarded, averager outputs counted
// DONE  | one-cycle completion pulse, then IDLE
module avg_acq_ctrl #(
    parameter int BITS_ADC   = 8,
    parameter int BITS_ACUM  = 12,
    parameter int BITS_NSAMP = 16,
    localparam int BIT_DIFF  = BITS_ACUM - BITS_ADC,
    localparam int KW        = (BIT_DIFF > 1) ? $clog2(BIT_DIFF) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [KW-1:0]         k_cfg,
    input  logic [BITS_NSAMP-1:0] n_samples_cfg,
    input  logic                  adc_rdy,
    input  logic                  avg_rdy_out,
    output logic                  avg_rst,
    output logic [KW-1:0]         avg_k,
    output logic                  avg_rdy_in,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [BITS_NSAMP-1:0] out_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // The averager's down-counter is BIT_DIFF bits wide, so 1<<BIT_DIFF
    // would wrap to zero; k is limited to BIT_DIFF-1.
    localparam logic [KW-1:0] K_MAX = KW'(BIT_DIFF - 1);

    state_t                  state_q, state_d;
    logic [KW-1:0]           k_q, k_d;
    logic [BITS_NSAMP-1:0]   n_q, n_d;
    logic [BITS_NSAMP-1:0]   cnt_q, cnt_d;
    logic                    aborted_q, aborted_d;
    logic [KW-1:0]           k_clamped;

    assign k_clamped = (k_cfg > K_MAX) ? K_MAX : k_cfg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            n_q       <= '0;
            cnt_q     <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            n_q       <= n_d;
            cnt_q     <= cnt_d;
            aborted_q <= aborted_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        n_d       = n_q;
        cnt_d     = cnt_q;
        aborted_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    k_d     = k_clamped;
                    n_d     = n_samples_cfg;
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Abort takes priority over a coincident final output: the
                // block is discarded, so that output is not counted.
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (avg_rdy_out) begin
                    cnt_d = cnt_q + BITS_NSAMP'(1);
                    if ((n_q != '0) && (cnt_q == n_q - BITS_NSAMP'(1))) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign avg_rst    = rst | (state_q == S_LOAD);
    assign avg_k      = k_q;
    assign avg_rdy_in = adc_rdy & (state_q == S_RUN);
    assign busy       = (state_q == S_LOAD) | (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign aborted    = aborted_q;
    assign out_cnt    = cnt_q;

endmodule
